// File: rtl/eros_obi_responder_pkg.sv
// Shared types and width helpers for the OBI SRAM responder.
package eros_obi_responder_pkg;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_entry_t;

   function automatic int calc_idx_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int calc_cnt_w(input int latency);
      return $clog2(latency + 1);
   endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the cluster's external-slave port.
package obi_pkg;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

// File: rtl/eros_resp_fifo.sv
// In-order pending-response FIFO; push and pop may coincide even when full.
module eros_resp_fifo
   import eros_obi_responder_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push,
   input  resp_entry_t entry,
   input  logic        pop,
   output logic        full,
   output logic        empty,
   output resp_entry_t head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   resp_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] count;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= next_ptr(wptr);
         if (pop)  rptr <= next_ptr(rptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // When full, wptr == rptr: the head is consumed this cycle while the slot is rewritten.
   always_ff @(posedge clk_i) begin
      if (push) mem[wptr] <= entry;
   end

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rptr];

endmodule

// File: rtl/eros_obi_responder.sv
// OBI responder backed by a word-addressed SRAM with programmable in-order response latency.
module eros_obi_responder
   import obi_pkg::*;
   import eros_obi_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH       = 256,
   parameter int          LATENCY     = 1,
   parameter int          OUTSTANDING = 2,
   parameter logic [31:0] ERR_DATA    = 32'hBADC_AB1E
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  obi_req_t  obi_req_i,
   output obi_resp_t obi_resp_o,
   input  logic      stall_i,
   output logic      err_o,
   output logic      busy_o
);

   localparam int IDX_W = calc_idx_w(DEPTH);
   localparam int CNT_W = calc_cnt_w(LATENCY);
   localparam logic [32:0]      BASE_EXT  = {1'b0, BASE_ADDR};
   localparam logic [32:0]      LIMIT_EXT = BASE_EXT + 33'(4 * DEPTH);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

   logic [31:0]      sram [DEPTH];
   logic [32:0]      addr_ext;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic [31:0]      rd_word;

   logic             gnt;
   logic             pop;
   logic             full;
   logic             empty;
   resp_entry_t      entry;
   resp_entry_t      head;
   logic [CNT_W-1:0] cnt;
   logic             unused_head_err;

   // 33-bit compare keeps the upper bound from wrapping at the top of the map.
   assign addr_ext = {1'b0, obi_req_i.addr};
   assign in_range = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
   assign idx      = obi_req_i.addr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
   assign rd_word  = sram[idx];

   assign pop = ~empty & (cnt == '0);
   assign gnt = obi_req_i.req & ~stall_i & (~full | pop) & ~rst_i;

   always_comb begin
      entry.err   = ~in_range;
      entry.rdata = '0;
      if (!obi_req_i.we) entry.rdata = in_range ? rd_word : ERR_DATA;
   end

   always_ff @(posedge clk_i) begin
      if (gnt && obi_req_i.we && in_range) begin
         for (int k = 0; k < 4; k++) begin
            if (obi_req_i.be[k]) sram[idx][8*k +: 8] <= obi_req_i.wdata[8*k +: 8];
         end
      end
   end

   eros_resp_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (gnt),
      .entry (entry),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   // Reload on every head change; a reload into an empty FIFO is harmless since rvalid needs ~empty.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if ((gnt && empty) || pop) begin
         cnt <= CNT_LOAD;
      end else if (!empty && cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign obi_resp_o.gnt    = gnt;
   assign obi_resp_o.rvalid = pop;
   assign obi_resp_o.rdata  = pop ? head.rdata : '0;
   assign err_o             = gnt & ~in_range;
   assign busy_o            = ~empty;
   assign unused_head_err   = head.err;

endmodule

// File: tb/tb_eros_obi_responder.sv
// Directed bench for eros_obi_responder at LATENCY 1, 3 and 4.
module tb_eros_obi_responder;
   import obi_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   obi_req_t  req1, req3, req4;
   obi_resp_t resp1, resp3, resp4;
   logic      stall1, stall3, stall4;
   logic      err1, err3, err4, busy1, busy3, busy4;

   int n_checks = 0;
   int n_fail   = 0;

   logic        q_we    [8];
   logic [31:0] q_addr  [8];
   logic [31:0] q_wdata [8];
   int          g_cyc   [8];
   int          v_cyc   [8];
   logic [31:0] v_data  [8];
   logic        gnt_at  [16];
   logic        busy_at [16];
   int          ng, nv;

   always #5 clk = ~clk;

   eros_obi_responder #(.LATENCY(1), .OUTSTANDING(2)) u1 (
      .clk_i(clk), .rst_i(rst), .obi_req_i(req1), .obi_resp_o(resp1),
      .stall_i(stall1), .err_o(err1), .busy_o(busy1));
   eros_obi_responder #(.LATENCY(3), .OUTSTANDING(2)) u3 (
      .clk_i(clk), .rst_i(rst), .obi_req_i(req3), .obi_resp_o(resp3),
      .stall_i(stall3), .err_o(err3), .busy_o(busy3));
   eros_obi_responder #(.LATENCY(4), .OUTSTANDING(2)) u4 (
      .clk_i(clk), .rst_i(rst), .obi_req_i(req4), .obi_resp_o(resp4),
      .stall_i(stall4), .err_o(err4), .busy_o(busy4));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transaction on u1: waits for gnt, then for rvalid, both bounded.
   task automatic op1(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, output int gwait, output logic errs,
                      output int lat, output logic [31:0] rd);
      req1.req = 1'b1; req1.we = we; req1.be = be; req1.addr = addr; req1.wdata = wdata;
      gwait = 0; errs = 1'bx; lat = -1; rd = 'x;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (resp1.gnt) begin errs = err1; break; end
         gwait++;
         step();
      end
      step();
      req1 = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (resp1.rvalid) begin lat = i; rd = resp1.rdata; break; end
         step();
      end
      step();
   endtask

   task automatic run3(input int nreq, input int ncyc);
      ng = 0; nv = 0;
      for (int k = 0; k < 8; k++) begin g_cyc[k] = -1; v_cyc[k] = -1; v_data[k] = 'x; end
      for (int c = 0; c < ncyc; c++) begin
         if (ng < nreq) begin
            req3.req = 1'b1; req3.we = q_we[ng]; req3.be = 4'hF;
            req3.addr = q_addr[ng]; req3.wdata = q_wdata[ng];
         end else begin
            req3 = '0;
         end
         @(negedge clk);
         gnt_at[c] = resp3.gnt; busy_at[c] = busy3;
         if (resp3.rvalid && nv < 8) begin v_cyc[nv] = c; v_data[nv] = resp3.rdata; nv++; end
         if (resp3.gnt && ng < 8) begin g_cyc[ng] = c; ng++; end
         step();
      end
      req3 = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req1 = '0; req1.req = 1'b1;
      #3;
      n_checks++; if ({resp1, err1, busy1} !== '0) begin n_fail++; $display("FAIL reset_u1 got resp=%h err=%b busy=%b exp all 0", resp1, err1, busy1); end
      n_checks++; if ({resp3, err3, busy3} !== '0) begin n_fail++; $display("FAIL reset_u3 got resp=%h err=%b busy=%b exp all 0", resp3, err3, busy3); end
      n_checks++; if ({resp4, err4, busy4} !== '0) begin n_fail++; $display("FAIL reset_u4 got resp=%h err=%b busy=%b exp all 0", resp4, err4, busy4); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      req1 = '0;
   endtask

   task automatic test_write_read();
      int gw, l; logic e; logic [31:0] d;
      op1(1'b1, 4'hF, 32'h10, 32'hCAFEF00D, gw, e, l, d);
      n_checks++; if (gw !== 0 || e !== 1'b0 || l !== 1 || d !== 32'h0) begin n_fail++; $display("FAIL wr_10 got gw=%0d err=%b lat=%0d rdata=%h exp 0 0 1 00000000", gw, e, l, d); end
      op1(1'b0, 4'hF, 32'h10, 32'h0, gw, e, l, d);
      n_checks++; if (gw !== 0 || e !== 1'b0 || l !== 1 || d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_10 got gw=%0d err=%b lat=%0d rdata=%h exp 0 0 1 cafef00d", gw, e, l, d); end
      op1(1'b0, 4'hF, 32'h13, 32'h0, gw, e, l, d);
      n_checks++; if (e !== 1'b0 || l !== 1 || d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_13_lowbits got err=%b lat=%0d rdata=%h exp 0 1 cafef00d", e, l, d); end
   endtask

   task automatic test_byte_enables();
      int gw, l; logic e; logic [31:0] d;
      op1(1'b1, 4'hF, 32'h20, 32'h11223344, gw, e, l, d);
      op1(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, gw, e, l, d);
      op1(1'b0, 4'hF, 32'h20, 32'h0, gw, e, l, d);
      n_checks++; if (l !== 1 || d !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_0101 got lat=%0d rdata=%h exp 1 11bb33dd", l, d); end
      op1(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, gw, e, l, d);
      n_checks++; if (gw !== 0 || l !== 1 || d !== 32'h0) begin n_fail++; $display("FAIL be_0_resp got gw=%0d lat=%0d rdata=%h exp 0 1 00000000", gw, l, d); end
      op1(1'b0, 4'hF, 32'h20, 32'h0, gw, e, l, d);
      n_checks++; if (d !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_0_noop got rdata=%h exp 11bb33dd", d); end
   endtask

   task automatic test_out_of_range();
      int gw, l; logic e; logic [31:0] d;
      op1(1'b1, 4'hF, 32'h0, 32'h0BADF00D, gw, e, l, d);
      op1(1'b0, 4'hF, 32'h400, 32'h0, gw, e, l, d);
      n_checks++; if (gw !== 0 || e !== 1'b1 || l !== 1 || d !== 32'hBADCAB1E) begin n_fail++; $display("FAIL oor_rd got gw=%0d err=%b lat=%0d rdata=%h exp 0 1 1 badcab1e", gw, e, l, d); end
      op1(1'b1, 4'hF, 32'h400, 32'h12345678, gw, e, l, d);
      n_checks++; if (e !== 1'b1 || l !== 1 || d !== 32'h0) begin n_fail++; $display("FAIL oor_wr got err=%b lat=%0d rdata=%h exp 1 1 00000000", e, l, d); end
      op1(1'b0, 4'hF, 32'h0, 32'h0, gw, e, l, d);
      n_checks++; if (e !== 1'b0 || d !== 32'h0BADF00D) begin n_fail++; $display("FAIL oor_wr_dropped got err=%b rdata=%h exp 0 0badf00d", e, d); end
      op1(1'b1, 4'hF, 32'h3FC, 32'h5A5A0001, gw, e, l, d);
      op1(1'b0, 4'hF, 32'h3FC, 32'h0, gw, e, l, d);
      n_checks++; if (e !== 1'b0 || d !== 32'h5A5A0001) begin n_fail++; $display("FAIL last_word got err=%b rdata=%h exp 0 5a5a0001", e, d); end
      op1(1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, gw, e, l, d);
      n_checks++; if (e !== 1'b1 || d !== 32'hBADCAB1E) begin n_fail++; $display("FAIL top_of_map got err=%b rdata=%h exp 1 badcab1e", e, d); end
   endtask

   task automatic test_stall();
      stall1 = 1'b1;
      req1 = '0; req1.req = 1'b1; req1.be = 4'hF; req1.addr = 32'h20;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if (resp1.gnt !== 1'b0 || resp1.rvalid !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL stall_c%0d got gnt=%b rvalid=%b busy=%b exp 0 0 0", i, resp1.gnt, resp1.rvalid, busy1); end
         step();
      end
      stall1 = 1'b0;
      @(negedge clk);
      n_checks++; if (resp1.gnt !== 1'b1) begin n_fail++; $display("FAIL stall_release_gnt got %b exp 1", resp1.gnt); end
      step();
      req1 = '0;
      @(negedge clk);
      n_checks++; if (resp1.rvalid !== 1'b1 || resp1.rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL stall_release_rsp got rvalid=%b rdata=%h exp 1 11bb33dd", resp1.rvalid, resp1.rdata); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a [3];
      logic [31:0] x [3];
      a[0] = 32'h10; a[1] = 32'h20; a[2] = 32'h0;
      x[0] = 32'hCAFEF00D; x[1] = 32'h11BB33DD; x[2] = 32'h0BADF00D;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            req1 = '0; req1.req = 1'b1; req1.be = 4'hF; req1.addr = a[i];
         end else begin
            req1 = '0;
         end
         @(negedge clk);
         n_checks++; if (resp1.gnt !== (i < 3)) begin n_fail++; $display("FAIL b2b_gnt_c%0d got %b exp %b", i, resp1.gnt, (i < 3)); end
         n_checks++; if (resp1.rvalid !== (i > 0) || resp1.rdata !== ((i > 0) ? x[(i > 0) ? i - 1 : 0] : 32'h0)) begin n_fail++; $display("FAIL b2b_rsp_c%0d got rvalid=%b rdata=%h", i, resp1.rvalid, resp1.rdata); end
         step();
      end
   endtask

   task automatic test_latency_backpressure();
      int eg [3];
      int ev [3];
      eg[0] = 0; eg[1] = 1; eg[2] = 3;
      ev[0] = 3; ev[1] = 6; ev[2] = 9;
      for (int k = 0; k < 3; k++) begin q_we[k] = 1'b1; q_addr[k] = 32'(4 * k); q_wdata[k] = 32'hA000_0000 + 32'(k); end
      run3(3, 12);
      n_checks++; if (ng !== 3 || nv !== 3 || v_data[0] !== 32'h0 || v_data[2] !== 32'h0) begin n_fail++; $display("FAIL lat3_writes got ng=%0d nv=%0d d0=%h d2=%h exp 3 3 0 0", ng, nv, v_data[0], v_data[2]); end
      for (int k = 0; k < 3; k++) q_we[k] = 1'b0;
      run3(3, 12);
      n_checks++; if (gnt_at[2] !== 1'b0 || busy_at[2] !== 1'b1) begin n_fail++; $display("FAIL lat3_full_c2 got gnt=%b busy=%b exp 0 1", gnt_at[2], busy_at[2]); end
      n_checks++; if (ng !== 3 || nv !== 3) begin n_fail++; $display("FAIL lat3_counts got ng=%0d nv=%0d exp 3 3", ng, nv); end
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (g_cyc[k] !== eg[k] || v_cyc[k] !== ev[k] || v_data[k] !== 32'hA000_0000 + 32'(k)) begin n_fail++; $display("FAIL lat3_rd%0d got gnt_c=%0d rv_c=%0d rdata=%h exp %0d %0d a000000%0d", k, g_cyc[k], v_cyc[k], v_data[k], eg[k], ev[k], k); end
      end
   endtask

   task automatic test_reset_mid();
      int stale; int gc; int vc; logic ec; logic [31:0] dc;
      req4 = '0; req4.req = 1'b1; req4.be = 4'hF; req4.addr = 32'h400;
      repeat (4) step();
      @(negedge clk);
      n_checks++; if (resp4.gnt !== 1'b1 || resp4.rvalid !== 1'b1 || err4 !== 1'b1 || busy4 !== 1'b1 || resp4.rdata !== 32'hBADCAB1E) begin n_fail++; $display("FAIL lat4_pre_reset got gnt=%b rvalid=%b err=%b busy=%b rdata=%h exp 1 1 1 1 badcab1e", resp4.gnt, resp4.rvalid, err4, busy4, resp4.rdata); end
      #1 rst = 1'b1;
      #1;
      n_checks++; if ({resp4, err4, busy4} !== '0) begin n_fail++; $display("FAIL async_reset got resp=%h err=%b busy=%b exp all 0", resp4, err4, busy4); end
      step();
      req4 = '0;
      step();
      rst = 1'b0;
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (resp4.rvalid !== 1'b0 || busy4 !== 1'b0) stale++;
         step();
      end
      n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL no_stale_rvalid got %0d bad cycles exp 0", stale); end
      req4.req = 1'b1; req4.be = 4'hF; req4.addr = 32'h400;
      gc = -1; vc = -1; ec = 1'b0; dc = 'x;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (resp4.gnt && gc < 0) begin gc = c; ec = err4; end
         if (resp4.rvalid && vc < 0) begin vc = c; dc = resp4.rdata; end
         step();
         if (gc >= 0) req4 = '0;
      end
      n_checks++; if (gc !== 0 || ec !== 1'b1 || vc !== 4 || dc !== 32'hBADCAB1E) begin n_fail++; $display("FAIL post_reset_rd got gnt_c=%0d err=%b rv_c=%0d rdata=%h exp 0 1 4 badcab1e", gc, ec, vc, dc); end
   endtask

   initial begin
      req1 = '0; req3 = '0; req4 = '0;
      stall1 = 1'b0; stall3 = 1'b0; stall4 = 1'b0;
      test_reset();
      test_write_read();
      test_byte_enables();
      test_out_of_range();
      test_stall();
      test_back_to_back();
      test_latency_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached after %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
